fifo_push_arbiter: RTL and testbench



---
 rtl/fifo_push_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO push port among REQ_COUNT
// write-domain requesters. One arbitration cycle per burst; accepted beats are
// forwarded to the FIFO combinationally in the same cycle.
module fifo_push_arbiter #(
  parameter int unsigned REQ_COUNT  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            ENABLE,
  input  logic [REQ_COUNT-1:0]            REQ_VALID,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [REQ_COUNT-1:0]            REQ_LAST,
  output logic [REQ_COUNT-1:0]            REQ_READY,
  output logic                            GRANT_VALID,
  output logic [$clog2(REQ_COUNT)-1:0]    GRANT_ID,
  output logic                            W_nEN,
  output logic [DATA_WIDTH-1:0]           W_DATA,
  input  logic                            W_FULL,
  output logic                            BUSY
);

  localparam int unsigned IdW  = $clog2(REQ_COUNT);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]      grant_id_q, grant_id_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
  logic                accept;
  logic                burst_end;
  logic                found;
  logic [IdW-1:0]      winner;

  // Pick the first valid requester at or after rr_ptr, wrapping modulo REQ_COUNT.
  always_comb begin
    int unsigned     idx;
    logic [IdW-1:0]  cand;
    idx    = 0;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < REQ_COUNT; k++) begin
      idx  = (32'(rr_ptr_q) + k) % REQ_COUNT;
      cand = IdW'(idx);
      if (!found && REQ_VALID[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Owner handshake and FIFO write path; reset blocks any push immediately.
  always_comb begin
    accept    = 1'b0;
    REQ_READY = '0;
    W_DATA    = '0;
    if (state_q == StBurst && !RST) begin
      REQ_READY[grant_id_q] = ~W_FULL;
      accept                = REQ_VALID[grant_id_q] & ~W_FULL;
      W_DATA                = REQ_DATA[32'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
    end
    W_nEN     = ~accept;
    burst_end = accept & (REQ_LAST[grant_id_q] | ((32'(beat_cnt_q) + 1) == MAX_BURST));
  end

  // Next-state: grant in IDLE, count beats and release the port in BURST.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ENABLE && found) begin
          state_d    = StBurst;
          grant_id_d = winner;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
        if (burst_end) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_id_q == IdW'(REQ_COUNT - 1)) ? '0 : grant_id_q + IdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign GRANT_VALID = (state_q == StBurst);
  assign GRANT_ID    = grant_id_q;
  assign BUSY        = (state_q == StBurst) | (|REQ_VALID);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized bench for fifo_push_arbiter: producers stream tagged bursts of
// random length, and a transaction-level reference model predicts grants and
// pushes each cycle.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic            ENABLE;
  logic [N-1:0]    REQ_VALID;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_LAST;
  logic [N-1:0]    REQ_READY;
  logic            GRANT_VALID;
  logic [IW-1:0]   GRANT_ID;
  logic            W_nEN;
  logic [DW-1:0]   W_DATA;
  logic            W_FULL;
  logic            BUSY;

  fifo_push_arbiter #(
    .REQ_COUNT (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENABLE     (ENABLE),
    .REQ_VALID  (REQ_VALID),
    .REQ_DATA   (REQ_DATA),
    .REQ_LAST   (REQ_LAST),
    .REQ_READY  (REQ_READY),
    .GRANT_VALID(GRANT_VALID),
    .GRANT_ID   (GRANT_ID),
    .W_nEN      (W_nEN),
    .W_DATA     (W_DATA),
    .W_FULL     (W_FULL),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Producer state: next sequence number and beats left in the current burst.
  int seq [N];
  int left[N];

  // Reference model: owner is -1 when no burst is in progress.
  int m_owner, m_ptr, m_beats, m_gid, m_acc_id;
  bit m_acc;
  int pushes_exp, pushes_got;

  function automatic logic [31:0] beat_word(input int i, input int s);
    return (i << 24) | (s & 'hFFFFFF);
  endfunction

  task automatic model_step();
    logic [N-1:0] exp_ready;
    bit any;
    any = |REQ_VALID;
    if (RST) begin
      m_owner = -1;
      m_ptr   = 0;
      m_gid   = 0;
      m_beats = 0;
    end
    check_eq("grant_valid", 32'(GRANT_VALID), 32'(m_owner >= 0));
    check_eq("grant_id", 32'(GRANT_ID), m_gid);
    check_eq("busy", 32'(BUSY), 32'((m_owner >= 0) || any));
    exp_ready = '0;
    m_acc     = 1'b0;
    if (!RST && m_owner >= 0) begin
      if (!W_FULL) exp_ready[m_owner] = 1'b1;
      m_acc = REQ_VALID[m_owner] && !W_FULL;
    end
    check_eq("req_ready", 32'(REQ_READY), 32'(exp_ready));
    check_eq("w_nen", 32'(W_nEN), 32'(!m_acc));
    if (m_acc) check_eq("w_data", W_DATA, beat_word(m_owner, seq[m_owner]));
    if (m_owner < 0) check_eq("w_data_idle", W_DATA, 32'd0);
    if (m_acc) pushes_exp++;
    if (W_nEN === 1'b0) pushes_got++;
    if (RST) return;
    if (m_owner < 0) begin
      if (ENABLE && any) begin
        for (int k = 0; k < N; k++) begin
          if (REQ_VALID[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_gid   = m_owner;
        m_beats = 0;
      end
    end else if (m_acc) begin
      m_acc_id = m_owner;
      m_beats++;
      if (REQ_LAST[m_owner] || m_beats == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    RST       = 1'b1;
    ENABLE    = 1'b0;
    W_FULL    = 1'b0;
    REQ_VALID = '0;
    REQ_LAST  = '0;
    REQ_DATA  = '0;
    m_owner   = -1;
    m_ptr     = 0;
    m_gid     = 0;
    m_beats   = 0;
    m_acc     = 1'b0;
    m_acc_id  = 0;
    pushes_exp = 0;
    pushes_got = 0;
    for (int i = 0; i < N; i++) begin
      seq[i]  = 0;
      left[i] = $urandom_range(1, 6);
    end
    repeat (2) @(posedge CLK);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge CLK);
      #1;
      // Retire the beat pushed at this edge; start a new burst when one ends.
      if (m_acc) begin
        seq[m_acc_id]++;
        left[m_acc_id]--;
        if (left[m_acc_id] == 0) left[m_acc_id] = $urandom_range(1, 6);
      end
      RST    = (cyc < 2) || ($urandom_range(0, 249) == 0);
      ENABLE = ($urandom_range(0, 9) != 0);
      W_FULL = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        REQ_VALID[i]           = ($urandom_range(0, 4) != 0);
        REQ_LAST[i]            = (left[i] == 1);
        REQ_DATA[i*DW +: DW]   = beat_word(i, seq[i]);
      end
      @(negedge CLK);
      model_step();
    end
    check_eq("push_count", pushes_got, pushes_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
